decode_ctrl: RTL and testbench

Instruction-side control decoder feeding the fetch unit. Takes the ROM word addressed by the previous cycle's PC and produces TYPE, B1_OUT, PC_VAL and SR_IN for the fetch unit. Holds the condition-flag register, evaluates branch conditions, and enforces the one-cycle branch delay slot. Tracks subroutine depth so that an overflowing BSR or underflowing RET never reaches the fetch unit's 3-entry return stack.

---
 rtl/decode_ctrl.sv | 144 ++++++++++++++
 tb/tb_decode_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Instruction-side control decoder: flag register, branch evaluation, delay-slot
// enforcement and optional subroutine-depth guard (macro DECODE_STACK_GUARD_EN).
module decode_ctrl (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] ROM_DATA,
  input  logic [3:0]  FLAGS_IN,
  input  logic        FLAGS_WE,
  output logic [6:0]  TYPE,
  output logic        B1_OUT,
  output logic [10:0] PC_VAL,
  output logic        SR_IN,
  output logic [15:0] IR_OUT,
  output logic        STACK_ERR,
  output logic        SLOT_ERR
);

  // state | meaning
  // WAIT  | first cycle after reset, ROM output stale, word squashed
  // RUN   | normal decode
  // SLOT  | delay slot after an issued transfer, control words squashed
  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SLOT = 2'd2;

  localparam logic [2:0] OP_JMP = 3'd0;
  localparam logic [2:0] OP_BZ  = 3'd1;
  localparam logic [2:0] OP_BNZ = 3'd2;
  localparam logic [2:0] OP_BC  = 3'd3;
  localparam logic [2:0] OP_BN  = 3'd4;
  localparam logic [2:0] OP_BV  = 3'd5;
  localparam logic [2:0] OP_BSR = 3'd6;
  localparam logic [2:0] OP_RET = 3'd7;

  logic [1:0]  state, state_nxt;
  logic [3:0]  flags;
  logic        stack_err_q, slot_err_q;
  logic        is_ctrl, cond, stack_block, issue, slot_viol, stack_hit;
  logic [2:0]  op;
  logic [6:0]  type_c;
  logic        b1_c, sr_c;
  logic [10:0] pc_c;
  logic [15:0] ir_c;

  assign is_ctrl = ROM_DATA[15];
  assign op      = ROM_DATA[14:12];

  // flags = {N,V,C,Z}
  always_comb begin
    cond = 1'b1;
    case (op)
      OP_BZ:   cond = flags[0];
      OP_BNZ:  cond = ~flags[0];
      OP_BC:   cond = flags[1];
      OP_BN:   cond = flags[3];
      OP_BV:   cond = flags[2];
      default: cond = 1'b1;
    endcase
  end

`ifdef DECODE_STACK_GUARD_EN
  logic [1:0] depth;

  assign stack_block = ((op == OP_BSR) && (depth == 2'd3)) ||
                       ((op == OP_RET) && (depth == 2'd0));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      depth <= 2'd0;
    else if (issue && (op == OP_BSR))
      depth <= depth + 2'd1;
    else if (issue && (op == OP_RET))
      depth <= depth - 2'd1;
  end
`else
  assign stack_block = 1'b0;
`endif

  assign issue     = (state == ST_RUN) && is_ctrl && cond && !stack_block;
  assign stack_hit = (state == ST_RUN) && is_ctrl && stack_block;
  assign slot_viol = (state == ST_SLOT) && is_ctrl;

  always_comb begin
    type_c = 7'd0;
    b1_c   = 1'b0;
    sr_c   = 1'b0;
    pc_c   = 11'd0;
    ir_c   = 16'd0;
    if (state != ST_WAIT) begin
      if (!is_ctrl) begin
        type_c = {1'b0, ROM_DATA[14:9]};
        ir_c   = ROM_DATA;
      end else if (issue) begin
        type_c = {4'b1000, op};
        b1_c   = (op != OP_RET);
        sr_c   = (op == OP_BSR) || (op == OP_RET);
        if (op == OP_BSR)
          pc_c = {1'b0, ROM_DATA[9:0]};
        else if (op != OP_RET)
          pc_c = ROM_DATA[10:0];
        ir_c   = ROM_DATA;
      end else if ((state == ST_RUN) && !stack_block) begin
        // not-taken branch still executes; fetch just increments
        ir_c   = ROM_DATA;
      end
    end
  end

  always_comb begin
    state_nxt = ST_WAIT;
    case (state)
      ST_WAIT: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = issue ? ST_SLOT : ST_RUN;
      ST_SLOT: state_nxt = ST_RUN;
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_WAIT;
      flags       <= 4'd0;
      stack_err_q <= 1'b0;
      slot_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (FLAGS_WE)
        flags <= FLAGS_IN;
      if (stack_hit)
        stack_err_q <= 1'b1;
      if (slot_viol)
        slot_err_q <= 1'b1;
    end
  end

  assign TYPE      = nreset ? type_c : 7'd0;
  assign B1_OUT    = nreset & b1_c;
  assign PC_VAL    = nreset ? pc_c : 11'd0;
  assign SR_IN     = nreset & sr_c;
  assign IR_OUT    = nreset ? ir_c : 16'd0;
  assign STACK_ERR = nreset & stack_err_q;
  assign SLOT_ERR  = nreset & slot_err_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: directed scenarios then random words,
// checked against an instruction-level reference model.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] ROM_DATA = 16'd0;
  logic [3:0]  FLAGS_IN = 4'd0;
  logic        FLAGS_WE = 1'b0;
  logic [6:0]  TYPE;
  logic        B1_OUT;
  logic [10:0] PC_VAL;
  logic        SR_IN;
  logic [15:0] IR_OUT;
  logic        STACK_ERR;
  logic        SLOT_ERR;

  decode_ctrl dut (
    .clk(clk), .nreset(nreset), .ROM_DATA(ROM_DATA), .FLAGS_IN(FLAGS_IN),
    .FLAGS_WE(FLAGS_WE), .TYPE(TYPE), .B1_OUT(B1_OUT), .PC_VAL(PC_VAL),
    .SR_IN(SR_IN), .IR_OUT(IR_OUT), .STACK_ERR(STACK_ERR), .SLOT_ERR(SLOT_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  typ;
    logic        b1;
    logic [10:0] pc;
    logic        sr;
    logic [15:0] ir;
    logic        serr;
    logic        lerr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_fresh;
  bit       m_in_slot;
  int       m_depth;
  bit [3:0] m_flags;
  bit       m_serr, m_lerr;

  task automatic model_step(input logic [15:0] w, input logic fwe, input logic [3:0] fin,
                            input logic rst, input string tag, output exp_t e);
    bit taken, blocked;
    int op;
    e = '{typ: 7'd0, b1: 1'b0, pc: 11'd0, sr: 1'b0, ir: 16'd0,
          serr: m_serr, lerr: m_lerr, tag: tag};
    if (rst) begin
      e.serr = 1'b0; e.lerr = 1'b0;
      m_fresh = 1; m_in_slot = 0; m_depth = 0; m_flags = 0; m_serr = 0; m_lerr = 0;
      return;
    end
    if (m_fresh) begin
      m_fresh = 0;
    end else if (!w[15]) begin
      e.typ = {1'b0, w[14:9]};
      e.ir = w;
      m_in_slot = 0;
    end else if (m_in_slot) begin
      m_lerr = 1;
      m_in_slot = 0;
    end else begin
      op = int'(w[14:12]);
      case (op)
        1: taken = m_flags[0];
        2: taken = !m_flags[0];
        3: taken = m_flags[1];
        4: taken = m_flags[3];
        5: taken = m_flags[2];
        default: taken = 1;
      endcase
      blocked = 0;
`ifdef DECODE_STACK_GUARD_EN
      if ((op == 6 && m_depth == 3) || (op == 7 && m_depth == 0)) blocked = 1;
`endif
      if (blocked) begin
        m_serr = 1;
      end else if (taken) begin
        e.typ = 7'h40 + 7'(op);
        e.ir = w;
        e.b1 = (op != 7);
        e.sr = (op >= 6);
        if (op == 6) e.pc = 11'(w[9:0]);
        else if (op < 6) e.pc = w[10:0];
        if (op == 6) m_depth++;
        if (op == 7) m_depth--;
        m_in_slot = 1;
      end else begin
        e.ir = w;
      end
    end
    if (fwe) m_flags = fin;
  endtask

  task automatic step(input logic [15:0] w, input logic fwe, input logic [3:0] fin,
                      input logic rst, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    nreset = !rst;
    ROM_DATA = w;
    FLAGS_WE = fwe;
    FLAGS_IN = fin;
    model_step(w, fwe, fin, rst, tag, e);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (TYPE !== e.typ || B1_OUT !== e.b1 || PC_VAL !== e.pc || SR_IN !== e.sr ||
          IR_OUT !== e.ir || STACK_ERR !== e.serr || SLOT_ERR !== e.lerr) begin
        errors++;
        $display("FAIL %s @%0t rom=%h got type=%h b1=%b pc=%h sr=%b ir=%h serr=%b lerr=%b want type=%h b1=%b pc=%h sr=%b ir=%h serr=%b lerr=%b",
                 e.tag, $time, ROM_DATA, TYPE, B1_OUT, PC_VAL, SR_IN, IR_OUT, STACK_ERR, SLOT_ERR,
                 e.typ, e.b1, e.pc, e.sr, e.ir, e.serr, e.lerr);
      end
    end
  end

  initial begin
    logic [15:0] w;
    logic        rst;
    step(16'h0000, 0, 4'h0, 1, "reset");
    step(16'h8005, 0, 4'h0, 0, "wait_squash");
    step(16'h8005, 0, 4'h0, 0, "jmp5");
    step(16'h0000, 0, 4'h0, 0, "jmp_slot");
    step(16'h0000, 1, 4'h1, 0, "load_z");
    step(16'hA010, 0, 4'h0, 0, "bnz_not_taken");
    step(16'h9010, 0, 4'h0, 0, "bz_taken");
    step(16'h0000, 0, 4'h0, 0, "bz_slot");
    step(16'hE003, 0, 4'h0, 0, "bsr");
    step(16'h1200, 0, 4'h0, 0, "bsr_slot");
    step(16'hF000, 0, 4'h0, 0, "ret");
    step(16'h0000, 0, 4'h0, 0, "ret_slot");
    for (int i = 0; i < 4; i++) begin
      step(16'hE3FF, 0, 4'h0, 0, "nested_bsr");
      step(16'h0400, 0, 4'h0, 0, "nested_slot");
    end
    for (int i = 0; i < 5; i++) begin
      step(16'hF000, 0, 4'h0, 0, "unwind_ret");
      step(16'h0000, 0, 4'h0, 0, "unwind_slot");
    end
    step(16'h8005, 0, 4'h0, 0, "jmp_a");
    step(16'h8006, 0, 4'h0, 0, "jmp_in_slot");
    step(16'h0000, 0, 4'h0, 0, "after_slot_err");
    step(16'h8FFF, 0, 4'h0, 0, "jmp_bit11");
    step(16'h0000, 1, 4'h0, 0, "clear_z");
    step(16'h9010, 1, 4'h1, 0, "bz_same_cycle_we");
    step(16'h9010, 0, 4'h0, 0, "bz_next_cycle");
    step(16'h8001, 0, 4'h0, 1, "reset_mid_slot");
    step(16'h8001, 0, 4'h0, 0, "wait_after_reset");
    step(16'h8001, 0, 4'h0, 0, "jmp_after_reset");
    for (int i = 0; i < 3000; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) != 0) w[15] = 1'b1;
      rst = ($urandom_range(0, 149) == 0);
      step(w, 1'($urandom_range(0, 3) == 0), 4'($urandom), rst, "random");
    end
    @(posedge clk);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain remaining=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
